// File: rtl/gf163_reduce.sv
// GF(2^163) reduction of a 325-bit carry-less product mod x^163+x^7+x^6+x^3+1; 2-edge latency, one op in flight,
// result held in DONE until out_ready. Define GF163_RED_EARLY_EN for 1-edge completion when p[324:163] is zero.
module gf163_reduce #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [324:0]     p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [162:0]     r,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [168:0]   acc;
    logic [168:0]   p_fold;
    logic [162:0]   acc_fold;
    logic           acc_ld;
    logic           r_ld;
    logic           cnt_inc;

    // First fold: the 162-bit high part lands at most at bit 161+7 = 168.
    function automatic logic [168:0] fold_wide(input logic [324:0] c);
        logic [168:0] h;
        h = {7'd0, c[324:163]};
        return {6'd0, c[162:0]} ^ h ^ (h << 3) ^ (h << 6) ^ (h << 7);
    endfunction

    // Second fold: only six high bits remain, so the result never reaches bit 163.
    function automatic logic [162:0] fold_narrow(input logic [168:0] c);
        logic [5:0] h;
        h = c[168:163];
        return c[162:0]
             ^ {157'd0, h}
             ^ {154'd0, h, 3'd0}
             ^ {151'd0, h, 6'd0}
             ^ {150'd0, h, 7'd0};
    endfunction

    assign p_fold   = fold_wide(p);
    assign acc_fold = fold_narrow(acc);

`ifdef GF163_RED_EARLY_EN
    logic p_hi_zero;
    logic r_ld_early;
    assign p_hi_zero = (p[324:163] == 162'd0);
`endif

    always_comb begin
        state_nxt  = state;
        acc_ld     = 1'b0;
        r_ld       = 1'b0;
        cnt_inc    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
`ifdef GF163_RED_EARLY_EN
        r_ld_early = 1'b0;
`endif
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
`ifdef GF163_RED_EARLY_EN
                    if (p_hi_zero) begin
                        r_ld_early = 1'b1;
                        state_nxt  = DONE;
                    end else begin
                        acc_ld    = 1'b1;
                        state_nxt = FOLD;
                    end
`else
                    acc_ld    = 1'b1;
                    state_nxt = FOLD;
`endif
                end
            end
            FOLD: begin
                r_ld      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    cnt_inc   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            r        <= '0;
            done_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (acc_ld) begin
                acc <= p_fold;
            end
            if (r_ld) begin
                r <= acc_fold;
            end
`ifdef GF163_RED_EARLY_EN
            else if (r_ld_early) begin
                r <= p[162:0];
            end
`endif
            if (cnt_inc) begin
                done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_gf163_reduce.sv
// Scoreboard bench for gf163_reduce: directed scenarios plus random Karatsuba-style products
// checked against a bit-serial polynomial long-division reference.
module tb_gf163_reduce;

    localparam int CW = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [324:0]   p;
    logic           out_valid;
    logic           out_ready;
    logic [162:0]   r;
    logic           busy;
    logic [CW-1:0]  done_cnt;

    gf163_reduce #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks = 0;
    int errors = 0;
    int exp_done = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    typedef struct {
        logic [162:0] r;
        int           acc_edge;
        int           lat;
    } exp_t;
    exp_t q[$];

    task automatic chk_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at edge %0d", name, act, req, edges);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, edges);
        end
    endtask

    task automatic chk_r(input string name, input logic [162:0] act, input logic [162:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at edge %0d", name, act, req, edges);
        end
    endtask

    function automatic logic [324:0] rnd325();
        logic [324:0] v;
        v = '0;
        for (int i = 0; i < 11; i++) v = {v[292:0], $urandom()};
        return v;
    endfunction

    function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
        logic [324:0] acc;
        logic [324:0] aw;
        acc = '0;
        aw  = {162'd0, a};
        for (int i = 0; i < 163; i++) begin
            if (b[i]) acc = acc ^ (aw << i);
        end
        return acc;
    endfunction

    // Textbook long division: cancel each set bit above 162 with a shifted copy of f(x).
    function automatic logic [162:0] ref_mod(input logic [324:0] v);
        logic [324:0] f;
        logic [324:0] w;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        w = v;
        for (int i = 324; i >= 163; i--) begin
            if (w[i]) w = w ^ (f << (i - 163));
        end
        return w[162:0];
    endfunction

    function automatic int lat_of(input logic [324:0] v);
`ifdef GF163_RED_EARLY_EN
        return (v[324:163] == 162'd0) ? 1 : 2;
`else
        return (v[324] === 1'b0) ? 2 : 2;
`endif
    endfunction

    // Called at posedge+1; offers val until accepted and records the expectation on acceptance.
    task automatic send(input logic [324:0] val, input logic [162:0] expr);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        p        = val;
        for (int k = 0; k < 200 && !acc; k++) begin
            if (in_ready) begin
                q.push_back('{expr, edges + 1, lat_of(val)});
                acc = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready never rose at edge %0d", edges);
        end
        in_valid = 1'b0;
        p        = rnd325();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", q.size());
        end
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: derives expected handshake signals from the scoreboard head and its accept edge.
    initial begin
        bit exp_busy;
        bit exp_valid;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                exp_done = 0;
            end else begin
                exp_busy  = (q.size() != 0) && (edges >= q[0].acc_edge);
                exp_valid = exp_busy && ((edges - q[0].acc_edge) >= (q[0].lat - 1));
                chk_int("done_cnt", int'(done_cnt), exp_done % (1 << CW));
                chk_bit("in_ready", in_ready, !exp_busy);
                chk_bit("busy", busy, exp_busy);
                chk_bit("out_valid", out_valid, exp_valid);
                if (exp_valid) begin
                    chk_r("r", r, q[0].r);
                    if (out_ready) begin
                        void'(q.pop_front());
                        exp_done++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog simulation time limit reached at edge %0d", edges);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [162:0] e2;
        logic [162:0] held;
        logic [162:0] a;
        logic [162:0] b;
        logic [324:0] prod;
        logic [324:0] v;
        int           saved_cnt;
        int           n;
        bit           exp_ov;

        rst = 1'b1; in_valid = 1'b0; p = '0; rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_r("reset_r", r, 163'd0);
        chk_int("reset_done_cnt", int'(done_cnt), 0);
        chk_bit("reset_in_ready", in_ready, 1'b1);
        chk_bit("reset_out_valid", out_valid, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Scenario 1 and 2: single and double fold.
        send(325'd1 << 163, 163'hC9);
        drain();
        chk_int("s1_done_cnt", int'(done_cnt), 1);
        e2 = (163'd1 << 161) ^ 163'h1422;
        send(325'd1 << 324, e2);
        drain();

        // Scenario 3: small operand, latency depends on early completion.
        send(325'h1234, 163'h1234);
`ifdef GF163_RED_EARLY_EN
        exp_ov = 1'b1;
`else
        exp_ov = 1'b0;
`endif
        chk_bit("s3_latency", out_valid, exp_ov);
        drain();
        send(325'd0, 163'd0);
        drain();

        // Scenario 4: stall in DONE, a new offer must be ignored.
        rdy_mode = 2;
        v = rnd325();
        send(v, ref_mod(v));
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        held      = ref_mod(v);
        saved_cnt = int'(done_cnt);
        in_valid  = 1'b1;
        p         = rnd325();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_bit("s4_in_ready", in_ready, 1'b0);
            chk_bit("s4_out_valid", out_valid, 1'b1);
            chk_r("s4_r_stable", r, held);
            chk_int("s4_done_cnt", int'(done_cnt), saved_cnt);
            @(posedge clk); #1;
            if (i == 2) in_valid = 1'b0;
        end
        rdy_mode = 0;
        drain();

        // Scenario 5: reset while folding.
        send(325'd1 << 163, 163'hC9);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_bit("s5_in_ready", in_ready, 1'b1);
        chk_bit("s5_out_valid", out_valid, 1'b0);
        chk_bit("s5_busy", busy, 1'b0);
        chk_int("s5_done_cnt", int'(done_cnt), 0);
        @(posedge clk); #1;
        send(325'd1 << 163, 163'hC9);
        drain();
        chk_int("s5_done_after", int'(done_cnt), 1);

        // Scenario 6: random products with random output backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            v    = rnd325();
            a    = v[162:0];
            v    = rnd325();
            b    = v[162:0];
            prod = clmul(a, b);
            send(prod, ref_mod(prod));
        end
        drain();
        chk_int("s6_done_cnt", int'(done_cnt), 1001);

        // Extra traffic carries the counter past its wrap point.
        for (int i = 0; i < 30; i++) begin
            v = rnd325();
            if (i % 3 == 0) v[324:163] = '0;
            send(v, ref_mod(v));
        end
        drain();
        chk_int("wrap_done_cnt", int'(done_cnt), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
